// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared sizes, state encoding and byte helper for the MAC array sequencer
package mac_seq_pkg;
  localparam int N       = 8;
  localparam int DATA_W  = 8;
  localparam int WORD_W  = N * DATA_W;
  localparam int IDX_W   = $clog2(N);
  localparam int FIFO_B  = 0;
  localparam int FIFO_A0 = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAITD  = 3'd2,
    S_UNPACK = 3'd3,
    S_RUN    = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // Byte j of a memory word, most significant byte first.
  function automatic logic [DATA_W-1:0] byte_sel(input logic [WORD_W-1:0] w,
                                                 input logic [IDX_W-1:0]  j);
    return w[WORD_W-1 - DATA_W*int'(j) -: DATA_W];
  endfunction
endpackage

// File: rtl/mac_skew_sr.sv
// rtl/mac_skew_sr.sv - delay line turning the lane-0 enable into staggered A-row pops
module mac_skew_sr #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_i,
  input  logic         flush_i,
  output logic [N-1:0] q_o,
  output logic         empty_o
);
  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  assign sr_d = {sr_q[N-2:0], shift_i};

  always_ff @(posedge clk) begin
    if (rst || flush_i) sr_q <= '0;
    else                sr_q <= sr_d;
  end

  assign q_o     = sr_q;
  assign empty_o = ~|sr_q;
endmodule

// File: rtl/mac_array_seq.sv
// rtl/mac_array_seq.sv - fetches B and A rows, fills the input FIFOs, then
// streams them through the systolic MAC array with skewed pops
module mac_array_seq
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic [N:0]        fifo_wrreq,
  input  logic [N:0]        fifo_full,
  input  logic [N:0]        fifo_empty,
  output logic              rdreq_b,
  output logic [N-1:0]      rdreq_a,
  output logic              mac_en0,
  output logic              mac_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_o
);
  localparam int K_W   = $clog2(N + 2);
  localparam int LAT_W = $clog2(MAC_LAT + 2);

  state_e            state_q;
  logic [K_W-1:0]    k_q;
  logic [IDX_W-1:0]  j_q;
  logic [IDX_W-1:0]  beat_q;
  logic [LAT_W-1:0]  lat_q;
  logic [WORD_W-1:0] word_q;
  logic              en_q, clr_q, done_q, err_q;

  logic              en_d;
  logic              wr_ok, last_byte, underflow, skew_empty;
  logic [N-1:0]      skew;

  assign wr_ok     = (state_q == S_UNPACK) && !fifo_full[k_q];
  assign last_byte = wr_ok && (j_q == IDX_W'(N - 1));
  assign underflow = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                     ((en_q && fifo_empty[FIFO_B]) || (|(skew & fifo_empty[N:FIFO_A0])));

  // Lane-0 enable for the next cycle; it also feeds the skew line so row r lags by r.
  assign en_d = !underflow &&
                ((last_byte && (k_q == K_W'(N))) ||
                 ((state_q == S_RUN) && (beat_q != IDX_W'(N - 1))));

  mac_skew_sr #(.N(N)) u_skew (
    .clk     (clk),
    .rst     (rst),
    .shift_i (en_d),
    .flush_i (underflow),
    .q_o     (skew),
    .empty_o (skew_empty)
  );

  always_comb begin
    mem_read    = (state_q == S_FETCH);
    mem_address = mem_read ? base_addr + ADDR_W'(k_q) : '0;
    fifo_wdata  = (state_q == S_UNPACK) ? byte_sel(word_q, j_q) : '0;
    fifo_wrreq  = wr_ok ? ({{N{1'b0}}, 1'b1} << k_q) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      word_q  <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q   <= en_d;
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      if (underflow) begin
        err_q   <= 1'b1;
        done_q  <= 1'b1;
        state_q <= S_DONE;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            clr_q   <= 1'b1;
            err_q   <= 1'b0;
            k_q     <= '0;
            state_q <= S_FETCH;
          end
          S_FETCH: if (!mem_waitrequest) state_q <= S_WAITD;
          S_WAITD: if (mem_readdatavalid) begin
            word_q  <= mem_readdata;
            j_q     <= '0;
            state_q <= S_UNPACK;
          end
          S_UNPACK: if (wr_ok) begin
            if (last_byte) begin
              j_q <= '0;
              k_q <= k_q + 1'b1;
              if (k_q == K_W'(N)) begin
                beat_q  <= '0;
                state_q <= S_RUN;
              end else begin
                state_q <= S_FETCH;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
          S_RUN: begin
            if (beat_q == IDX_W'(N - 1)) begin
              lat_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
          S_DRAIN: if (skew_empty) begin
            if (lat_q == LAT_W'(MAC_LAT)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              lat_q <= lat_q + 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rdreq_b = en_q;
  assign mac_en0 = en_q;
  assign rdreq_a = skew;
  assign mac_clr = clr_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != S_IDLE);
  assign state_o = state_q;
endmodule
